gen_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit free-running counter.
- Adds configurable width and modulus, up/down counting, enable, synchronous clear and load, and three terminal modes: wrap, saturate and one-shot.
- Provides a terminal-count pulse and a sticky overflow flag.
- Used as the general timing/event counter in datapath and control blocks.

---
 rtl/gen_counter.sv | 123 ++++++++++++
 tb/tb_gen_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gen_counter.sv
// Parametrised up/down event counter with wrap, saturate and one-shot terminal modes.
// Optional step prescaler is enabled by defining CNT_PRESCALE_EN.
module gen_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             step_ok;
    logic             at_term;

`ifdef CNT_PRESCALE_EN
    localparam int             PRE_W    = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Only the last enabled cycle of each PRESCALE-long interval is a step.
    always_comb begin
        pre_d   = pre_q;
        step_ok = 1'b0;
        if (clr || load) begin
            pre_d = '0;
        end else if (en && !done_q) begin
            if (pre_q == PRE_LAST) begin
                pre_d   = '0;
                step_ok = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end
`else
    localparam int unused_prescale = PRESCALE;

    assign step_ok = en && !done_q;
`endif

    assign at_term = up_dn ? (cnt_q == MAX_CNT) : (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q;
        done_d = done_q;
        if (clr) begin
            cnt_d  = '0;
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end else begin
            if (ovf_clr) ovf_d = 1'b0;
            if (load) begin
                cnt_d  = (load_val > MAX_CNT) ? MAX_CNT : load_val;
                done_d = 1'b0;
            end else if (step_ok) begin
                if (at_term) begin
                    // Setting after the clear above lets a terminal event beat ovf_clr.
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    case (mode_e'(mode))
                        MODE_SAT:     cnt_d  = cnt_q;
                        MODE_ONESHOT: done_d = 1'b1;
                        default:      cnt_d  = up_dn ? '0 : MAX_CNT;
                    endcase
                end else begin
                    cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

// File: tb/tb_gen_counter.sv
// Scoreboard bench for gen_counter (WIDTH=4, MAX_VAL=9, PRESCALE=4).
// Expectations follow the build: prescaler vectors when CNT_PRESCALE_EN is defined.
module tb_gen_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic [1:0] mode;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       ovf_clr;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    logic       done;

    gen_counter #(
        .WIDTH   (4),
        .MAX_VAL (9),
        .PRESCALE(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up_dn   (up_dn),
        .mode    (mode),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .ovf_clr (ovf_clr),
        .cnt     (cnt),
        .tc      (tc),
        .ovf     (ovf),
        .done    (done)
    );

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; the expected post-edge state is queued at the same time.
    task automatic drive(input string name,
                         input logic r, input logic e, input logic u, input logic [1:0] m,
                         input logic c, input logic l, input logic [3:0] lv, input logic oc,
                         input logic [3:0] ec, input logic et, input logic eo, input logic ed);
        exp_t x;
        @(negedge clk);
        rst_n    = r;
        en       = e;
        up_dn    = u;
        mode     = m;
        clr      = c;
        load     = l;
        load_val = lv;
        ovf_clr  = oc;
        x.name = name;
        x.cnt  = ec;
        x.tc   = et;
        x.ovf  = eo;
        x.done = ed;
        exp_q.push_back(x);
    endtask

    // Monitor: one registered result per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({cnt, tc, ovf, done} !== {e.cnt, e.tc, e.ovf, e.done}) begin
                    n_fail++;
                    $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b done=%0b, expected cnt=%0d tc=%0b ovf=%0b done=%0b",
                             e.name, cnt, tc, ovf, done, e.cnt, e.tc, e.ovf, e.done);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; mode = 2'b00;
        clr = 1'b0; load = 1'b0; load_val = 4'd0; ovf_clr = 1'b0;

        //          name          rst en up mode  clr ld lv     oc   cnt   tc ovf done
        drive("reset",            0, 0, 1, 2'b00, 0, 0, 4'd0,  0,  4'd0, 0, 0, 0);

`ifndef CNT_PRESCALE_EN
        for (int i = 1; i <= 12; i++)
            drive("wrap_up",      1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'(i % 10), (i == 10), (i >= 10), 0);

        drive("load2",            1, 0, 0, 2'b01, 0, 1, 4'd2,  0,  4'd2, 0, 1, 0);
        drive("ovf_clr",          1, 0, 0, 2'b01, 0, 0, 4'd0,  1,  4'd2, 0, 0, 0);
        drive("sat_dn1",          1, 1, 0, 2'b01, 0, 0, 4'd0,  0,  4'd1, 0, 0, 0);
        drive("sat_dn0",          1, 1, 0, 2'b01, 0, 0, 4'd0,  0,  4'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive("sat_hold",     1, 1, 0, 2'b01, 0, 0, 4'd0,  0,  4'd0, 1, 1, 0);

        drive("clr",              1, 0, 1, 2'b10, 1, 0, 4'd0,  0,  4'd0, 0, 0, 0);
        for (int i = 1; i <= 14; i++)
            drive("oneshot",      1, 1, 1, 2'b10, 0, 0, 4'd0,  0,
                  (i < 9) ? 4'(i) : 4'd9, (i == 10), (i >= 10), (i >= 10));
        drive("oneshot_load3",    1, 0, 1, 2'b10, 0, 1, 4'd3,  0,  4'd3, 0, 1, 0);
        drive("oneshot_resume",   1, 1, 1, 2'b10, 0, 0, 4'd0,  0,  4'd4, 0, 1, 0);

        drive("load_clamp",       1, 0, 1, 2'b00, 0, 1, 4'd15, 0,  4'd9, 0, 1, 0);
        drive("rsvd_mode_wrap",   1, 1, 1, 2'b11, 0, 0, 4'd0,  0,  4'd0, 1, 1, 0);
        drive("clr_over_load",    1, 1, 1, 2'b00, 1, 1, 4'd7,  0,  4'd0, 0, 0, 0);
        drive("term_vs_ovf_clr",  1, 1, 0, 2'b00, 0, 0, 4'd0,  1,  4'd9, 1, 1, 0);
        drive("ovf_clr_alone",    1, 0, 0, 2'b00, 0, 0, 4'd0,  1,  4'd9, 0, 0, 0);
        drive("down_step",        1, 1, 0, 2'b00, 0, 0, 4'd0,  0,  4'd8, 0, 0, 0);

        drive("clr2",             1, 0, 1, 2'b00, 1, 0, 4'd0,  0,  4'd0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            drive("count_to5",    1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive("en_low_hold",  1, 0, 1, 2'b00, 0, 0, 4'd0,  0,  4'd5, 0, 0, 0);
        drive("en_resume",        1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd6, 0, 0, 0);
        drive("load9",            1, 0, 1, 2'b10, 0, 1, 4'd9,  0,  4'd9, 0, 0, 0);
        drive("oneshot_term",     1, 1, 1, 2'b10, 0, 0, 4'd0,  0,  4'd9, 1, 1, 1);
        drive("mid_reset",        0, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd0, 0, 0, 0);
        drive("after_reset",      1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd1, 0, 0, 0);
`else
        for (int i = 1; i <= 16; i++)
            drive("pre_count",    1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'(i / 4), 0, 0, 0);
        drive("pre_mid1",         1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd4, 0, 0, 0);
        drive("pre_mid2",         1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd4, 0, 0, 0);
        drive("pre_load7",        1, 1, 1, 2'b00, 0, 1, 4'd7,  0,  4'd7, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            drive("pre_restart",  1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  (i == 4) ? 4'd8 : 4'd7, 0, 0, 0);
        drive("pre_en1",          1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd8, 0, 0, 0);
        drive("pre_en2",          1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd8, 0, 0, 0);
        drive("pre_hold1",        1, 0, 1, 2'b00, 0, 0, 4'd0,  0,  4'd8, 0, 0, 0);
        drive("pre_hold2",        1, 0, 1, 2'b00, 0, 0, 4'd0,  0,  4'd8, 0, 0, 0);
        drive("pre_en3",          1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd8, 0, 0, 0);
        drive("pre_en4_step",     1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd9, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            drive("pre_wrap",     1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  (i == 4) ? 4'd0 : 4'd9, (i == 4), (i == 4), 0);
        drive("pre_en_a",         1, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd0, 0, 1, 0);
        drive("pre_clr",          1, 1, 1, 2'b00, 1, 0, 4'd0,  0,  4'd0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            drive("pre_after_clr", 1, 1, 1, 2'b00, 0, 0, 4'd0, 0,  (i == 4) ? 4'd1 : 4'd0, 0, 0, 0);
        drive("pre_reset",        0, 1, 1, 2'b00, 0, 0, 4'd0,  0,  4'd0, 0, 0, 0);
`endif

        repeat (3) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
